// File: rtl/mem_access_unit.sv
// MEM-stage access unit: wait-stated data memory plus the MEM/WB output register.
// Optional feature macro MEM_ALIGN_CHECK_EN: misaligned requests are flagged on align_err, not performed.
module mem_access_unit #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 3,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned DEST_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              mem_w_en_in,
    input  logic              mem_r_en_in,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] mem_read_value,
    output logic [DATA_W-1:0] pc,
    output logic [DEST_W-1:0] dest,
    output logic              mem_ready,
    output logic              align_err
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_INIT = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic              req;
    logic              misalign;
    logic              go;
    logic              commit;

    // Word index wraps modulo DEPTH; addresses below BASE_ADDR wrap too.
    assign req    = mem_r_en_in | mem_w_en_in;
    assign offset = alu_result_in - DATA_W'(BASE_ADDR);
    assign idx    = IDX_W'(offset >> 2);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = req && (alu_result_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign go = req && !misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Access sequencing; commit marks the single edge where the access takes effect.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_ready = 1'b1;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    mem_ready = 1'b0;
                    if (WAIT_STATES == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_W'(CNT_INIT);
                    end
                end
            end
            BUSY: begin
                mem_ready = 1'b0;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!freeze) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit && mem_w_en_in) begin
            mem[idx] <= val_rm_in;
        end
    end

    // Output register: flush beats freeze beats stall bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en          <= 1'b0;
            mem_r_en       <= 1'b0;
            alu_result     <= '0;
            mem_read_value <= '0;
            pc             <= '0;
            dest           <= '0;
            align_err      <= 1'b0;
        end else if (flush) begin
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            align_err <= 1'b0;
        end else if (!freeze) begin
            if (!mem_ready) begin
                wb_en    <= 1'b0;
                mem_r_en <= 1'b0;
            end else begin
                wb_en      <= wb_en_in && !misalign;
                mem_r_en   <= mem_r_en_in && !misalign;
                alu_result <= alu_result_in;
                pc         <= pc_in;
                dest       <= dest_in;
                align_err  <= misalign;
                if (commit && mem_r_en_in) begin
                    mem_read_value <= mem[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit at default parameters (WAIT_STATES=3, BASE_ADDR=1024, DEPTH=64).
module tb_mem_access_unit;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WS    = 3;
    localparam int unsigned BASE  = 1024;
    localparam int unsigned DESTW = 4;

    typedef struct packed {
        logic             wb_en;
        logic             mem_r_en;
        logic [DW-1:0]    alu;
        logic [DW-1:0]    rd;
        logic [DW-1:0]    pc;
        logic [DESTW-1:0] dest;
        logic             aerr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             freeze, flush;
    logic             mem_w_en_in, mem_r_en_in, wb_en_in;
    logic [DW-1:0]    alu_result_in, val_rm_in, pc_in;
    logic [DESTW-1:0] dest_in;
    logic             wb_en, mem_r_en, mem_ready, align_err;
    logic [DW-1:0]    alu_result, mem_read_value, pc;
    logic [DESTW-1:0] dest;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t out_m;
    logic [DW-1:0] model [DEPTH];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .mem_w_en_in(mem_w_en_in), .mem_r_en_in(mem_r_en_in), .wb_en_in(wb_en_in),
        .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .pc_in(pc_in), .dest_in(dest_in),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
        .mem_read_value(mem_read_value), .pc(pc), .dest(dest),
        .mem_ready(mem_ready), .align_err(align_err)
    );

    function automatic int unsigned idx_of(input logic [DW-1:0] a);
        logic [DW-1:0] off;
        off = a - DW'(BASE);
        return (off >> 2) % DW'(DEPTH);
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.wb_en = wb_en; o.mem_r_en = mem_r_en; o.alu = alu_result; o.rd = mem_read_value;
        o.pc = pc; o.dest = dest; o.aerr = align_err;
        return o;
    endfunction

    task automatic drive_idle();
        mem_w_en_in = 1'b0; mem_r_en_in = 1'b0; wb_en_in = 1'b0; flush = 1'b0; freeze = 1'b0;
    endtask

    // Issue one instruction at posedge+1, push its expected result, pop and compare when it retires.
    task automatic run_op(input string name, input logic w, input logic r, input logic wb,
                          input logic [DW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] pcv, input logic [DESTW-1:0] d, input logic fl);
        exp_t e, o;
        logic mis;
        int   low, exp_low;
        bit   done;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (w | r) && (addr[1:0] != 2'b00);
`endif
        exp_low = ((w | r) && !mis) ? int'(WS) + 1 : 0;
        if (fl) begin
            e = out_m; e.wb_en = 1'b0; e.mem_r_en = 1'b0; e.aerr = 1'b0;
        end else begin
            e.wb_en = wb & !mis; e.mem_r_en = r & !mis; e.alu = addr; e.pc = pcv;
            e.dest = d; e.aerr = mis;
            e.rd = (r && !mis) ? model[idx_of(addr)] : out_m.rd;
        end
        if (w && !mis) model[idx_of(addr)] = data;
        sb.push_back(e);
        mem_w_en_in = w; mem_r_en_in = r; wb_en_in = wb; alu_result_in = addr;
        val_rm_in = data; pc_in = pcv; dest_in = d; flush = fl;
        low = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                done = 1;
            end else begin
                low++;
                @(posedge clk); #1;
                total++;
                if (wb_en !== 1'b0 || mem_r_en !== 1'b0 || alu_result !== out_m.alu) begin
                    bad++;
                    $display("FAIL %s bubble: got wb=%b mr=%b alu=%h, required wb=0 mr=0 alu=%h",
                             name, wb_en, mem_r_en, alu_result, out_m.alu);
                end
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: mem_ready still 0 after 40 cycles, required 1", name);
            void'(sb.pop_front());
        end else begin
            @(posedge clk); #1;
            o = observe();
            e = sb.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL %s result: got %h, required %h", name, o, e);
            end
            total++;
            if (low != exp_low) begin
                bad++;
                $display("FAIL %s stall: got %0d low cycles, required %0d", name, low, exp_low);
            end
            out_m = e;
        end
        drive_idle();
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (observe() !== exp_t'(0)) begin
            bad++; $display("FAIL reset outputs: got %h, required 0", observe());
        end
        total++;
        if (mem_ready !== 1'b1) begin
            bad++; $display("FAIL reset mem_ready: got %b, required 1", mem_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        out_m = '0;
    endtask

    task automatic test_passthrough();
        run_op("nop_a", 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h10, 4'd5, 1'b0);
        run_op("nop_b", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h14, 4'd15, 1'b0);
        run_op("nop_c", 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 32'h18, 4'd0, 1'b0);
    endtask

    task automatic test_store_load();
        run_op("store_1028", 1'b1, 1'b0, 1'b0, 32'd1028, 32'hDEAD_BEEF, 32'h20, 4'd1, 1'b0);
        run_op("load_1028", 1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 32'h24, 4'd2, 1'b0);
        run_op("store_1024", 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0000_0011, 32'h28, 4'd3, 1'b0);
        run_op("load_1024", 1'b0, 1'b1, 1'b1, 32'd1024, 32'h0, 32'h2C, 4'd4, 1'b0);
    endtask

    task automatic test_rw_same();
        run_op("rw_1028", 1'b1, 1'b1, 1'b1, 32'd1028, 32'h1234_5678, 32'h30, 4'd6, 1'b0);
        run_op("rw_check", 1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 32'h34, 4'd7, 1'b0);
    endtask

    task automatic test_wrap();
        run_op("wrap_store", 1'b1, 1'b0, 1'b0, DW'(BASE + 4 * DEPTH), 32'd7, 32'h40, 4'd8, 1'b0);
        run_op("wrap_load", 1'b0, 1'b1, 1'b1, DW'(BASE), 32'h0, 32'h44, 4'd9, 1'b0);
        run_op("below_store", 1'b1, 1'b0, 1'b0, DW'(BASE - 4), 32'h0BAD_CAFE, 32'h48, 4'd10, 1'b0);
        run_op("top_load", 1'b0, 1'b1, 1'b1, DW'(BASE + 4 * (DEPTH - 1)), 32'h0, 32'h4C, 4'd11, 1'b0);
`ifndef MEM_ALIGN_CHECK_EN
        run_op("lowbits_load", 1'b0, 1'b1, 1'b1, 32'd1031, 32'h0, 32'h50, 4'd12, 1'b0);
`endif
    endtask

    task automatic test_flush();
        run_op("flush_store", 1'b1, 1'b0, 1'b1, 32'd1040, 32'hF1F1_F1F1, 32'h60, 4'd1, 1'b1);
        run_op("flush_load", 1'b0, 1'b1, 1'b1, 32'd1040, 32'h0, 32'h64, 4'd2, 1'b1);
        run_op("after_flush", 1'b0, 1'b1, 1'b1, 32'd1040, 32'h0, 32'h68, 4'd3, 1'b0);
    endtask

    task automatic test_freeze();
        exp_t e, o, h;
        int   low;
        bit   done;
        h = out_m; h.wb_en = 1'b0; h.mem_r_en = 1'b0;
        e.wb_en = 1'b0; e.mem_r_en = 1'b0; e.alu = 32'd1036; e.rd = out_m.rd;
        e.pc = 32'h70; e.dest = 4'd5; e.aerr = 1'b0;
        model[idx_of(32'd1036)] = 32'hCAFE_F00D;
        sb.push_back(e);
        mem_w_en_in = 1'b1; mem_r_en_in = 1'b0; wb_en_in = 1'b0; alu_result_in = 32'd1036;
        val_rm_in = 32'hCAFE_F00D; pc_in = 32'h70; dest_in = 4'd5;
        low = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_ready) done = 1;
            else low++;
        end
        freeze = 1'b1;
        total++;
        if (!done || low != int'(WS) + 1) begin
            bad++; $display("FAIL freeze_stall: got %0d low cycles (done=%0d), required %0d", low, done, WS + 1);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            o = observe();
            total++;
            if (o !== h) begin
                bad++; $display("FAIL freeze_hold%0d: got %h, required %h", k, o, h);
            end
            @(negedge clk);
            total++;
            if (mem_ready !== 1'b1) begin
                bad++; $display("FAIL freeze_ready%0d: got %b, required 1", k, mem_ready);
            end
        end
        freeze = 1'b0;
        @(posedge clk); #1;
        o = observe();
        e = sb.pop_front();
        total++;
        if (o !== e) begin
            bad++; $display("FAIL freeze_release: got %h, required %h", o, e);
        end
        out_m = e;
        drive_idle();
        run_op("freeze_load", 1'b0, 1'b1, 1'b1, 32'd1036, 32'h0, 32'h74, 4'd6, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_op("seed_1032", 1'b1, 1'b0, 1'b0, 32'd1032, 32'hAAAA_5555, 32'h80, 4'd1, 1'b0);
        mem_w_en_in = 1'b1; alu_result_in = 32'd1032; val_rm_in = 32'h5555_AAAA;
        pc_in = 32'h84; dest_in = 4'd2;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_busy: got mem_ready=%b, required 0", mem_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (observe() !== exp_t'(0)) begin
            bad++; $display("FAIL rstmid_outputs: got %h, required 0", observe());
        end
        total++;
        if (mem_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_ready: got %b, required 0", mem_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        out_m = '0;
        run_op("rstmid_nowrite", 1'b0, 1'b1, 1'b1, 32'd1032, 32'h0, 32'h88, 4'd3, 1'b0);
        mem_w_en_in = 1'b1; alu_result_in = 32'd1032; val_rm_in = 32'h0C0C_0C0C;
        pc_in = 32'h8C; dest_in = 4'd4;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        out_m = '0;
        run_op("rstmid_restart", 1'b1, 1'b0, 1'b0, 32'd1032, 32'h0C0C_0C0C, 32'h8C, 4'd4, 1'b0);
        run_op("rstmid_load", 1'b0, 1'b1, 1'b1, 32'd1032, 32'h0, 32'h90, 4'd5, 1'b0);
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        run_op("align_load", 1'b0, 1'b1, 1'b1, 32'd1025, 32'h0, 32'hA0, 4'd6, 1'b0);
        run_op("align_clear", 1'b0, 1'b0, 1'b1, 32'd1025, 32'h0, 32'hA4, 4'd7, 1'b0);
        run_op("align_nowrite", 1'b1, 1'b0, 1'b0, 32'd1030, 32'hEEEE_EEEE, 32'hA8, 4'd8, 1'b0);
        run_op("align_check", 1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 32'hAC, 4'd9, 1'b0);
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic          w, r, wb;
            logic [DW-1:0] a;
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            a  = DW'(BASE) + DW'(4 * ($urandom_range(0, 4) + DEPTH * $urandom_range(0, 3)));
            run_op("b2b", w, r, wb, a, DW'($urandom), DW'(32'h400 + 4 * i), DESTW'(i), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        alu_result_in = '0; val_rm_in = '0; pc_in = '0; dest_in = '0;
        drive_idle();
        test_reset();
        test_passthrough();
        test_store_load();
        test_rw_same();
        test_wrap();
        test_flush();
        test_freeze();
        test_reset_mid();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, 32, data/address/PC width in bits.
REQ-002 Parameter DEPTH, 64, data-memory words (power of two).
REQ-003 Parameter WAIT_STATES, 3, extra stall cycles per access (0..15).
REQ-004 Parameter BASE_ADDR, 1024, byte address mapped to word 0.
REQ-005 Parameter DEST_W, 4, destination-register tag width.
REQ-006 Port clk input 1: single clock; all state changes on the rising edge.
REQ-007 Port rst input 1: asynchronous, active-low reset.
REQ-008 Port freeze input 1: hold the output register.
REQ-009 Port flush input 1: bubble the output register.
REQ-010 Ports mem_w_en_in, mem_r_en_in, wb_en_in input 1 each: EX-stage control.
REQ-011 Ports alu_result_in, val_rm_in, pc_in input DATA_W each: address/ALU value, store data, PC.
REQ-012 Port dest_in input DEST_W: writeback tag.
REQ-013 Ports wb_en, mem_r_en output 1 each: registered controls.
REQ-014 Ports alu_result, mem_read_value, pc output DATA_W each: registered values.
REQ-015 Port dest output DEST_W: registered tag.
REQ-016 Port mem_ready output 1: combinational; 0 stalls upstream stages.
REQ-017 Port align_err output 1: registered misaligned-access flag.

Function
REQ-018 Request = mem_r_en_in | mem_w_en_in; word index = ((alu_result_in - BASE_ADDR) >> 2) mod DEPTH (wraps, no error).
REQ-019 FSM states IDLE, BUSY, DONE; IDLE+request -> BUSY with cnt=WAIT_STATES-1, or -> DONE if WAIT_STATES=0.
REQ-020 BUSY: cnt decrements each cycle; cnt=0 -> DONE.
REQ-021 DONE: freeze=0 -> IDLE with access committed; freeze=1 -> stay in DONE, nothing committed.
REQ-022 mem_ready=0 in IDLE with request and in BUSY; otherwise 1. An access is therefore low for exactly WAIT_STATES+1 cycles.
REQ-023 Non-memory instruction: mem_ready=1, one-cycle pass-through.
REQ-024 Upstream holds all inputs stable while mem_ready=0; the block does not re-sample them.
REQ-025 Write commits on the DONE-exit edge only: mem[index] <= val_rm_in, exactly once per access.
REQ-026 Read: mem_read_value captures mem[index] on the DONE-exit edge.
REQ-027 Read and write together: the write is performed; mem_read_value gets the pre-write word.
REQ-028 Output register priority: flush > freeze > mem_ready.
REQ-029 flush=1: wb_en, mem_r_en, align_err <= 0; other fields hold.
REQ-030 freeze=1 (no flush): all outputs hold.
REQ-031 mem_ready=0 (no freeze/flush): bubble loaded: wb_en, mem_r_en <= 0; other fields hold.
REQ-032 Otherwise all outputs load from their *_in inputs; mem_read_value loads per REQ-026.
REQ-033 flush does not abort an in-progress access.

Reset
REQ-034 rst=0 asynchronously forces: FSM IDLE, cnt 0, all registered outputs 0; mem_ready then follows REQ-022.
REQ-035 Memory array contents are not reset; a mid-access reset abandons the access with no write committed.

Configuration
REQ-036 Macro MEM_ALIGN_CHECK_EN defined: request with alu_result_in[1:0] != 0 does not enter BUSY, mem_ready stays 1, no write; register loads wb_en=0, mem_r_en=0, align_err=1 for one cycle.
REQ-037 Macro MEM_ALIGN_CHECK_EN undefined: align_err tied 0; address bits [1:0] ignored.

Verification (WAIT_STATES=3, BASE_ADDR=1024)
REQ-038 Store: alu_result_in=1028, val_rm_in=0xDEADBEEF -> mem_ready low 4 cycles; mem[1]=0xDEADBEEF afterwards, written once.
REQ-039 Load: alu_result_in=1028, wb_en_in=1 -> 4 bubble cycles with wb_en=0, then wb_en=1 and mem_read_value=0xDEADBEEF.
REQ-040 Wrap: store 7 at 1024+4*DEPTH -> load from 1024 returns 7.
REQ-041 freeze=1 held 2 cycles while in DONE -> outputs held, one write only, completion delayed by 2 cycles.
REQ-042 rst=0 pulsed in BUSY during a store to 1032 -> outputs 0 immediately, mem[2] unchanged, FSM restarts the access from IDLE.
REQ-043 MEM_ALIGN_CHECK_EN defined, load at 1025 -> mem_ready stays 1, align_err=1 for one cycle, wb_en=0.
